// File: rtl/clock_set_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_pkg
// Description : Shared types, field encodings and BCD helpers for the
//               clock/calendar setting controller.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_set_pkg;

    localparam logic [2:0] c_FIELD_NONE  = 3'd0;
    localparam logic [2:0] c_FIELD_HOUR  = 3'd1;
    localparam logic [2:0] c_FIELD_MIN   = 3'd2;
    localparam logic [2:0] c_FIELD_AMPM  = 3'd3;
    localparam logic [2:0] c_FIELD_YEAR  = 3'd4;
    localparam logic [2:0] c_FIELD_MONTH = 3'd5;
    localparam logic [2:0] c_FIELD_DAY   = 3'd6;

    // Each set state is encoded as the field it edits, so edit_field is the state.
    typedef enum logic [2:0] {
        ST_RUN   = c_FIELD_NONE,
        ST_HOUR  = c_FIELD_HOUR,
        ST_MIN   = c_FIELD_MIN,
        ST_AMPM  = c_FIELD_AMPM,
        ST_YEAR  = c_FIELD_YEAR,
        ST_MONTH = c_FIELD_MONTH,
        ST_DAY   = c_FIELD_DAY
    } state_e;

    localparam logic [2:0] c_ST_RUN   = ST_RUN;
    localparam logic [2:0] c_ST_HOUR  = ST_HOUR;
    localparam logic [2:0] c_ST_MIN   = ST_MIN;
    localparam logic [2:0] c_ST_AMPM  = ST_AMPM;
    localparam logic [2:0] c_ST_YEAR  = ST_YEAR;
    localparam logic [2:0] c_ST_MONTH = ST_MONTH;
    localparam logic [2:0] c_ST_DAY   = ST_DAY;

    // Two-digit BCD values {tens, ones}; out-of-range inputs snap to the wrap target.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v >= hi || v < lo)
            return lo;
        else if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (v <= lo || v > hi)
            return hi;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
        logic [3:0] mod_sum;
        // (10*t + o) mod 4 == (2*t[0] + o) mod 4
        mod_sum = {2'b00, year[4], 1'b0} + year[3:0];
        case (month)
            8'h02:                      return (mod_sum[1:0] == 2'b00) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_set_ctrl_btn_repeat.sv
`default_nettype none
// ============================================================================
// Module      : btn_repeat
// Description : Press-edge detector with hold-to-repeat step generation.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_repeat #(
    parameter int DELAY_CYC = 500,
    parameter int RATE_CYC  = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clr,
    output logic press,
    output logic step
);

    localparam int c_MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
    localparam int c_CW      = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CW-1:0] c_DELAY_LAST = c_CW'(DELAY_CYC - 1);
    localparam logic [c_CW-1:0] c_RATE_LAST  = c_CW'(RATE_CYC - 1);

    logic            r_btn_q;
    logic            r_rep;
    logic [c_CW-1:0] r_cnt;
    logic            w_hit;

    assign press = btn & ~r_btn_q;
    assign w_hit = btn & (r_rep ? (r_cnt == c_RATE_LAST) : (r_cnt == c_DELAY_LAST));
    assign step  = (press | w_hit) & ~clr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_btn_q <= 1'b0;
            r_rep   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_btn_q <= btn;
            if (!btn || clr) begin
                r_cnt <= '0;
                r_rep <= 1'b0;
            end else if (w_hit) begin
                r_cnt <= '0;
                r_rep <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_ctrl
// Description : Button-driven time/date setting controller with auto-repeat,
//               edited-field blink, timeout abort and single-strobe load.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int BLINK_HZ        = 2,
    parameter int TIMEOUT_S       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       cur_am_pm,
    input  logic [3:0] cur_hour_10d,
    input  logic [3:0] cur_hour_1d,
    input  logic [3:0] cur_min_10d,
    input  logic [3:0] cur_min_1d,
    input  logic [3:0] cur_y_10d,
    input  logic [3:0] cur_y_1d,
    input  logic [3:0] cur_m_10d,
    input  logic [3:0] cur_m_1d,
    input  logic [3:0] cur_d_10d,
    input  logic [3:0] cur_d_1d,
    output logic       set_mode,
    output logic [2:0] edit_field,
    output logic       blink,
    output logic       load,
    output logic       new_am_pm,
    output logic [3:0] new_hour_10d,
    output logic [3:0] new_hour_1d,
    output logic [3:0] new_min_10d,
    output logic [3:0] new_min_1d,
    output logic [3:0] new_y_10d,
    output logic [3:0] new_y_1d,
    output logic [3:0] new_m_10d,
    output logic [3:0] new_m_1d,
    output logic [3:0] new_d_10d,
    output logic [3:0] new_d_1d
);

    localparam int c_DELAY_CYC   = (CLK_HZ / 1000) * REPEAT_DELAY_MS;
    localparam int c_RATE_CYC    = (CLK_HZ / 1000) * REPEAT_RATE_MS;
    localparam int c_BLINK_HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_TIMEOUT_CYC = CLK_HZ * TIMEOUT_S;
    localparam int c_BW          = $clog2(c_BLINK_HALF + 1);
    localparam int c_TW          = $clog2(c_TIMEOUT_CYC + 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST   = c_BW'(c_BLINK_HALF - 1);
    localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(c_TIMEOUT_CYC - 1);

    logic [2:0]      r_state;
    logic            r_mode_q;
    logic            r_load;
    logic            r_blink;
    logic [c_BW-1:0] r_blink_cnt;
    logic [c_TW-1:0] r_idle;
    logic            r_am_pm;
    logic [7:0]      r_hour;
    logic [7:0]      r_min;
    logic [7:0]      r_year;
    logic [7:0]      r_month;
    logic [7:0]      r_day;

    logic       w_mode_edge;
    logic       w_both;
    logic       w_up_press;
    logic       w_dn_press;
    logic       w_up_step;
    logic       w_dn_step;
    logic       w_set;
    logic       w_inc;
    logic       w_dec;
    logic       w_activity;
    logic       w_timeout;
    logic [7:0] w_dim;

    assign w_both = btn_up & btn_down;

    btn_repeat #(
        .DELAY_CYC (c_DELAY_CYC),
        .RATE_CYC  (c_RATE_CYC)
    ) u_rep_up (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_up),
        .clr   (w_both),
        .press (w_up_press),
        .step  (w_up_step)
    );

    btn_repeat #(
        .DELAY_CYC (c_DELAY_CYC),
        .RATE_CYC  (c_RATE_CYC)
    ) u_rep_dn (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_down),
        .clr   (w_both),
        .press (w_dn_press),
        .step  (w_dn_step)
    );

    assign w_mode_edge = btn_mode & ~r_mode_q;
    assign w_set       = (r_state != c_ST_RUN);
    // A mode edge in the same cycle as a step takes precedence; the step is lost.
    assign w_inc       = w_set & w_up_step & ~w_both & ~w_mode_edge;
    assign w_dec       = w_set & w_dn_step & ~w_both & ~w_mode_edge;
    assign w_activity  = w_mode_edge | w_up_press | w_dn_press | w_up_step | w_dn_step;
    assign w_timeout   = w_set & (r_idle == c_TIMEOUT_LAST);
    assign w_dim       = days_in_month(r_month, r_year);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= c_ST_RUN;
            r_mode_q <= 1'b0;
            r_load   <= 1'b0;
            r_am_pm  <= 1'b0;
            r_hour   <= 8'h01;
            r_min    <= 8'h00;
            r_year   <= 8'h00;
            r_month  <= 8'h01;
            r_day    <= 8'h01;
        end else begin
            r_mode_q <= btn_mode;
            r_load   <= 1'b0;
            if (w_mode_edge) begin
                case (r_state)
                    c_ST_RUN: begin
                        r_state <= c_ST_HOUR;
                        r_am_pm <= cur_am_pm;
                        r_hour  <= {cur_hour_10d, cur_hour_1d};
                        r_min   <= {cur_min_10d, cur_min_1d};
                        r_year  <= {cur_y_10d, cur_y_1d};
                        r_month <= {cur_m_10d, cur_m_1d};
                        r_day   <= {cur_d_10d, cur_d_1d};
                    end
                    c_ST_MONTH: begin
                        r_state <= c_ST_DAY;
                        if (r_day > w_dim)
                            r_day <= w_dim;
                    end
                    c_ST_DAY: begin
                        r_state <= c_ST_RUN;
                        r_load  <= 1'b1;
                    end
                    default: r_state <= r_state + 3'd1;
                endcase
            end else if (w_timeout) begin
                r_state <= c_ST_RUN;
            end else if (w_inc || w_dec) begin
                case (r_state)
                    c_ST_HOUR:  r_hour  <= w_inc ? bcd_inc(r_hour, 8'h01, 8'h12)
                                                 : bcd_dec(r_hour, 8'h01, 8'h12);
                    c_ST_MIN:   r_min   <= w_inc ? bcd_inc(r_min, 8'h00, 8'h59)
                                                 : bcd_dec(r_min, 8'h00, 8'h59);
                    c_ST_AMPM:  r_am_pm <= ~r_am_pm;
                    c_ST_YEAR:  r_year  <= w_inc ? bcd_inc(r_year, 8'h00, 8'h99)
                                                 : bcd_dec(r_year, 8'h00, 8'h99);
                    c_ST_MONTH: r_month <= w_inc ? bcd_inc(r_month, 8'h01, 8'h12)
                                                 : bcd_dec(r_month, 8'h01, 8'h12);
                    c_ST_DAY:   r_day   <= w_inc ? bcd_inc(r_day, 8'h01, w_dim)
                                                 : bcd_dec(r_day, 8'h01, w_dim);
                    default:    r_state <= r_state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
            r_idle      <= '0;
        end else begin
            if (!w_set || w_mode_edge || w_timeout || w_inc || w_dec) begin
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end

            if (!w_set || w_activity)
                r_idle <= '0;
            else
                r_idle <= r_idle + 1'b1;
        end
    end

    assign set_mode     = w_set;
    assign edit_field   = r_state;
    assign blink        = r_blink;
    assign load         = r_load;
    assign new_am_pm    = r_am_pm;
    assign new_hour_10d = r_hour[7:4];
    assign new_hour_1d  = r_hour[3:0];
    assign new_min_10d  = r_min[7:4];
    assign new_min_1d   = r_min[3:0];
    assign new_y_10d    = r_year[7:4];
    assign new_y_1d     = r_year[3:0];
    assign new_m_10d    = r_month[7:4];
    assign new_m_1d     = r_month[3:0];
    assign new_d_10d    = r_day[7:4];
    assign new_d_1d     = r_day[3:0];

endmodule
`default_nettype wire

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Button-driven time/date setting controller for the clock/calendar datapath. Freezes timekeeping while the user edits fields, cycles through hour, minute, AM/PM, year, month and day, and applies the edited value with a single load strobe. Sits between the debounced push-button inputs and the clock/calendar counters. The display path uses its blink and field outputs.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `REPEAT_DELAY_MS`, 500: hold time before auto-repeat starts.
- `REPEAT_RATE_MS`, 100: auto-repeat step period.
- `BLINK_HZ`, 2: edited-field blink frequency (full on/off period).
- `TIMEOUT_S`, 10: idle time in set mode before abort.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `btn_mode`, `btn_up`, `btn_down` in 1 each: debounced, synchronized button levels.
- `cur_am_pm` in 1: current AM/PM from the clock.
- `cur_hour_10d`, `cur_hour_1d`, `cur_min_10d`, `cur_min_1d` in 4 each: current time in BCD.
- `cur_y_10d`, `cur_y_1d`, `cur_m_10d`, `cur_m_1d`, `cur_d_10d`, `cur_d_1d` in 4 each: current date in BCD.
- `set_mode` out 1: high in every non-RUN state. The clock/calendar ignores `tick` while it is high.
- `edit_field` out 3: field under edit. 0 = none, 1 = hour, 2 = min, 3 = am/pm, 4 = year, 5 = month, 6 = day.
- `blink` out 1: display enable for the edited field. 1 = show.
- `load` out 1: one-cycle strobe that applies all `new_*` values.
- `new_am_pm`, `new_hour_*`, `new_min_*`, `new_y_*`, `new_m_*`, `new_d_*` out (1 / 4 each): edit registers in BCD. They mirror the `cur_*` names.

## Operation
- States:
  - RUN → S_HOUR → S_MIN → S_AMPM → S_YEAR → S_MONTH → S_DAY → RUN.
  - Each transition is taken on a rising edge of `btn_mode`.
- On RUN→S_HOUR, all `cur_*` values are captured into the edit registers in the same cycle.
- S_DAY→RUN asserts `load` and leaves the edit registers unchanged. Seconds are cleared by the clock on `load`; the controller has no seconds output.
- Up/down step the current field by ±1 with wrap-around:
  - Hour: 1..12.
  - Min: 0..59.
  - AM/PM: toggles.
  - Year: 00..99.
  - Month: 1..12.
  - Day: 1..max.
- Day maximum:
  - 31/30 per month.
  - February is 29 when `year % 4 == 0`, otherwise 28. Century is not edited.
- On entry to S_DAY, day is clamped to the maximum if it exceeds it (e.g. 31 with month 02, year 23 → 28).
- Per-button auto-repeat:
  - One step on the press edge.
  - Further steps after the button has been held `REPEAT_DELAY_MS`, then one every `REPEAT_RATE_MS` while held.
- Priority and conflicts:
  - `btn_up` and `btn_down` both high: no step, and both repeat timers are cleared.
  - A mode edge in the same cycle as a step: the mode edge wins and the step is dropped.
- Timeout:
  - No button activity for `TIMEOUT_S` in any set state → return to RUN with no `load` (abort).
  - The idle counter clears on any press edge or repeat step.
- In RUN, up/down are ignored.

## Timing
- Reset values (`reset` = 0 at a clock edge):
  - state RUN; `set_mode` = 0, `edit_field` = 0, `blink` = 1, `load` = 0.
  - All `new_*` = 0, except `new_hour_1d`, `new_m_1d` and `new_d_1d`, which reset to 1.
  - All counters and button history registers = 0.
- Reset during set mode discards the edit; no `load` is issued.
- Edge detection: `edge = btn & ~btn_q`. The state or field update is visible in the cycle after the edge cycle (1-cycle latency).
- `load` is registered:
  - It is high for exactly the first RUN cycle after S_DAY.
  - `set_mode` is already 0 in that cycle.
  - `new_*` are stable for the whole cycle.
- Blink:
  - `blink` toggles every `CLK_HZ/(2*BLINK_HZ)` cycles in set states.
  - The phase resets to 1 on every step and every state change.
  - `blink` = 1 in RUN.
- Counter widths use `$clog2` of the parameter-derived cycle counts.

## Structure
- Package `clock_set_pkg`:
  - State enum.
  - Field encoding constants.
  - BCD increment/decrement helpers.
  - `days_in_month(month, year)` function.
- Sub-module `btn_repeat`: edge detect plus auto-repeat timer. It outputs a one-cycle `step`, is instanced for up and down, and has a clear input for the both-pressed case.

## Test plan
Run with `CLK_HZ` = 1000, `REPEAT_DELAY_MS` = 500, `REPEAT_RATE_MS` = 100, `BLINK_HZ` = 2, `TIMEOUT_S` = 10.

1. Full edit cycle.
   - Stimulus: cur = 11:59 PM, 24-02-29. Press mode; up ×1 on hour; mode ×6.
   - Required: hour 12; one `load` pulse with 12:59 PM, 24-02-29. `set_mode` is high from the cycle after the first mode edge until `load`.
2. Wrap-around.
   - Stimulus: in S_MIN at 59, up. In S_MONTH at 01, down.
   - Required: minute → 00; month → 12.
3. Day clamp.
   - Stimulus: day = 31, month set to 02, year 23, then enter S_DAY.
   - Required: day = 28. With year 24: day = 29.
4. Auto-repeat.
   - Stimulus: hold up for 800 cycles in S_MIN starting at 00.
   - Required: steps at press +1, +500, +600, +700, +800 → minute = 05.
5. Timeout abort.
   - Stimulus: enter set mode, no presses for 10 000 cycles.
   - Required: state RUN, `load` never asserted, `set_mode` = 0.
6. Conflicts and reset.
   - Stimulus: up and down held together, then mode edge coincident with an up edge. Then `reset` = 0 mid-edit.
   - Required: no step; field advances with value unchanged; all outputs at reset values and no `load`.
